// File: rtl/opow_pkg.sv
// Shared definitions for the oBTC matrix-multiply controller and result packer.
package opow_pkg;
  localparam int unsigned N_ROWS = 64;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned HASH_W = N_ROWS * NIB_W;

  typedef enum logic [1:0] {IDLE, PACK, EMIT} packer_state_t;
endpackage

// File: rtl/opow_nibble_pack.sv
// Combinational reduction of PE results to nibbles, packed into one word.
// Optional HeavyHash final XOR controlled by OPOW_HASH_XOR_EN.
module opow_nibble_pack
  import opow_pkg::*;
#(
  parameter int unsigned PROD_W = 14,
  parameter int unsigned SHIFT  = 10
) (
  input  logic [N_ROWS*PROD_W-1:0] i_prod,
  input  logic [HASH_W-1:0]        i_hash,
  output logic [HASH_W-1:0]        o_result
);

  logic [HASH_W-1:0] w_nib;
  logic              w_unused_low;

  // Bits below SHIFT are discarded by design; fold them into a sink.
  always_comb begin
    w_nib        = '0;
    w_unused_low = 1'b0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      w_nib[r*NIB_W +: NIB_W] = i_prod[r*PROD_W + SHIFT +: NIB_W];
      w_unused_low            = w_unused_low ^ (^i_prod[r*PROD_W +: SHIFT]);
    end
  end

`ifdef OPOW_HASH_XOR_EN
  assign o_result = w_nib ^ i_hash;
`else
  logic w_unused_hash;
  assign w_unused_hash = ^i_hash;
  assign o_result      = w_nib;
`endif

endmodule

// File: rtl/opow_result_packer.sv
// Captures PE results, packs them to a nibble word and streams it as OUT_W beats.
// OPOW_HASH_XOR_EN enables the hash XOR and the hash capture register.
module opow_result_packer
  import opow_pkg::*;
#(
  parameter int unsigned PROD_W = 14,
  parameter int unsigned SHIFT  = 10,
  parameter int unsigned OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prod_valid,
  input  logic [N_ROWS*PROD_W-1:0] prod,
  input  logic [HASH_W-1:0]        hash_in,
  output logic                     busy,
  output logic                     ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last
);

  localparam int unsigned BEATS = HASH_W / OUT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  packer_state_t            r_state;
  logic [N_ROWS*PROD_W-1:0] r_prod;
  logic [HASH_W-1:0]        r_result;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic                     r_busy;
  logic                     r_ovf;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [OUT_W-1:0]         r_out_data;

  logic [HASH_W-1:0]        w_hash;
  logic [HASH_W-1:0]        w_result;
  logic [CNT_W-1:0]         w_next_cnt;
  logic                     w_hs;

`ifdef OPOW_HASH_XOR_EN
  logic [HASH_W-1:0] r_hash;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hash <= '0;
    end else if (prod_valid && r_state == IDLE) begin
      r_hash <= hash_in;
    end
  end
  assign w_hash = r_hash;
`else
  logic w_unused_hash_in;
  assign w_unused_hash_in = ^hash_in;
  assign w_hash           = '0;
`endif

  opow_nibble_pack #(
    .PROD_W (PROD_W),
    .SHIFT  (SHIFT)
  ) u_pack (
    .i_prod   (r_prod),
    .i_hash   (w_hash),
    .o_result (w_result)
  );

  assign w_hs       = r_out_valid && out_ready;
  assign w_next_cnt = r_beat_cnt + 1'b1;

  // out_data is preloaded one beat ahead so every output stays a plain register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_prod      <= '0;
      r_result    <= '0;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (prod_valid && r_state != IDLE) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (prod_valid) begin
            r_prod  <= prod;
            r_busy  <= 1'b1;
            r_state <= PACK;
          end
        end
        PACK: begin
          r_result    <= w_result;
          r_beat_cnt  <= '0;
          r_out_valid <= 1'b1;
          r_out_data  <= w_result[OUT_W-1:0];
          r_out_last  <= (BEATS == 1);
          r_state     <= EMIT;
        end
        EMIT: begin
          if (w_hs) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_beat_cnt <= w_next_cnt;
              r_out_data <= r_result[w_next_cnt*OUT_W +: OUT_W];
              r_out_last <= (w_next_cnt == LAST_BEAT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_opow_result_packer.sv
// Directed self-checking bench for opow_result_packer (either OPOW_HASH_XOR_EN setting).
module tb_opow_result_packer;
  import opow_pkg::*;

  localparam int unsigned PROD_W = 14;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned BEATS  = 8;
`ifdef OPOW_HASH_XOR_EN
  localparam bit XOR_ON = 1'b1;
`else
  localparam bit XOR_ON = 1'b0;
`endif

  localparam logic [HASH_W-1:0] PAT_A = {32'hFEDCBA98, 32'h76543210, 32'hCAFEF00D, 32'hDEADBEEF,
                                         32'h0F1E2D3C, 32'hA5A5A5A5, 32'h9ABCDEF0, 32'h12345678};
  localparam logic [HASH_W-1:0] PAT_B = {32'h31415926, 32'h53589793, 32'h23846264, 32'h33832795,
                                         32'h02884197, 32'h16939937, 32'h51058209, 32'h74944592};
  localparam logic [HASH_W-1:0] PAT_X = {64{4'h5}};

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     prod_valid = 1'b0;
  logic                     out_ready = 1'b0;
  logic [N_ROWS*PROD_W-1:0] prod = '0;
  logic [HASH_W-1:0]        hash_in = '0;
  logic                     busy, ovf, out_valid, out_last;
  logic [OUT_W-1:0]         out_data;

  int checks = 0;
  int errors = 0;

  opow_result_packer #(.PROD_W(PROD_W), .SHIFT(10), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .hash_in(hash_in),
    .busy(busy), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [N_ROWS*PROD_W-1:0] make_prod(input logic [HASH_W-1:0] nibs,
                                                         input logic [9:0] low);
    logic [N_ROWS*PROD_W-1:0] p;
    p = '0;
    for (int r = 0; r < int'(N_ROWS); r++) p[r*PROD_W +: PROD_W] = {nibs[r*NIB_W +: NIB_W], low};
    return p;
  endfunction

  function automatic logic [OUT_W-1:0] beat_of(input logic [HASH_W-1:0] w, input int b);
    return w[b*OUT_W +: OUT_W];
  endfunction

  // Called at a falling edge; returns one falling edge after the capture edge (cycle 1).
  task automatic launch(input logic [N_ROWS*PROD_W-1:0] p, input logic [HASH_W-1:0] h);
    prod       = p;
    hash_in    = h;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({busy, ovf, out_valid, out_last} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, expected 0000", {busy, ovf, out_valid, out_last});
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h, expected 00000000", out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_job;
    out_ready = 1'b1;
    launch(make_prod('0, 10'h3FF), '0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_latency: got valid=%b busy=%b, expected valid=0 busy=1", out_valid, busy);
    end
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, b == 7, 32'h0}) begin
        errors++; $display("FAIL zero_beat%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=00000000",
                           b, out_valid, out_last, out_data, b == 7);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, out_valid, out_last} !== 3'b000) begin
      errors++; $display("FAIL zero_end: got busy/valid/last=%b, expected 000", {busy, out_valid, out_last});
    end
  endtask

  task automatic test_max_products;
    logic [OUT_W-1:0] exp_w;
    exp_w = XOR_ON ? 32'h11111111 : 32'hEEEEEEEE;
    launch(make_prod({64{4'hE}}, 10'h040), {64{4'hF}});
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w) begin
        errors++; $display("FAIL max_beat%0d: got v=%b d=%h, expected v=1 d=%h", b, out_valid, out_data, exp_w);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    launch(make_prod(PAT_A, 10'h155), '0);
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, b == 7, beat_of(PAT_A, b)}) begin
        errors++; $display("FAIL bp_beat%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                           b, out_valid, out_last, out_data, b == 7, beat_of(PAT_A, b));
      end
      if (b == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL bp_hold%0d: got v=%b l=%b d=%h, expected v=1 l=0 d=a5a5a5a5",
                               s, out_valid, out_last, out_data);
          end
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_pre: got %b, expected 0", ovf);
    end
    launch(make_prod(PAT_A, 10'h2AA), '0);
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      prod_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== beat_of(PAT_A, b)) begin
        errors++; $display("FAIL ovf_beat%0d: got v=%b d=%h, expected v=1 d=%h", b, out_valid, out_data, beat_of(PAT_A, b));
      end
      if (b == 4) begin
        prod = make_prod(PAT_X, 10'h000);
        prod_valid = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if ({ovf, busy, out_valid} !== 3'b100) begin
      errors++; $display("FAIL ovf_after: got ovf/busy/valid=%b, expected 100", {ovf, busy, out_valid});
    end
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL ovf_no_restart: got busy/valid=%b, expected 00", {busy, out_valid});
    end
    launch(make_prod(PAT_B, 10'h000), '0);
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== beat_of(PAT_B, b) || ovf !== 1'b1) begin
        errors++; $display("FAIL ovf_next_beat%0d: got v=%b d=%h ovf=%b, expected v=1 d=%h ovf=1",
                           b, out_valid, out_data, ovf, beat_of(PAT_B, b));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    launch(make_prod(PAT_A, 10'h000), '0);
    for (int b = 0; b <= 4; b++) begin
      @(negedge clk);
      checks++;
      if (out_data !== beat_of(PAT_A, b)) begin
        errors++; $display("FAIL rstmid_beat%0d: got %h, expected %h", b, out_data, beat_of(PAT_A, b));
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, ovf} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags: got valid/last/busy/ovf=%b, expected 0000", {out_valid, out_last, busy, ovf});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(make_prod(PAT_B, 10'h3FF), '0);
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, b == 7, beat_of(PAT_B, b)}) begin
        errors++; $display("FAIL rstmid_new%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                           b, out_valid, out_last, out_data, b == 7, beat_of(PAT_B, b));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_last_collision;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL coll_pre: got ovf=%b, expected 0", ovf);
    end
    launch(make_prod(PAT_B, 10'h000), '0);
    for (int b = 0; b < int'(BEATS); b++) @(negedge clk);
    checks++;
    if (out_last !== 1'b1) begin
      errors++; $display("FAIL coll_last: got %b, expected 1", out_last);
    end
    prod = make_prod(PAT_X, 10'h000);
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    checks++;
    if ({ovf, busy, out_valid} !== 3'b100) begin
      errors++; $display("FAIL coll_ovf: got ovf/busy/valid=%b, expected 100", {ovf, busy, out_valid});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL coll_idle: got busy/valid=%b, expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_hash_only;
    logic [OUT_W-1:0] exp_w;
    exp_w = XOR_ON ? 32'hFFFFFFFF : 32'h00000000;
    launch(make_prod('0, 10'h000), {64{4'hF}});
    for (int b = 0; b < int'(BEATS); b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w) begin
        errors++; $display("FAIL hash_beat%0d: got v=%b d=%h, expected v=1 d=%h", b, out_valid, out_data, exp_w);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_zero_job;
    test_max_products;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    test_last_collision;
    test_hash_only;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
